// File: rtl/alu_pkg.sv
// Shared definitions for the ALU front end: funct codes,
// controller state encoding, default datapath width.
package alu_pkg;

  localparam int WIDTH_DEF = 32;

  localparam logic [5:0] OP_AND = 6'd36;
  localparam logic [5:0] OP_OR  = 6'd37;
  localparam logic [5:0] OP_ADD = 6'd32;
  localparam logic [5:0] OP_SUB = 6'd34;
  localparam logic [5:0] OP_SLT = 6'd42;

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] EXEC = 2'd1;
  localparam logic [1:0] RESP = 2'd2;

  function automatic logic op_legal(input logic [5:0] s);
    return (s == OP_AND) || (s == OP_OR) ||
           (s == OP_ADD) || (s == OP_SUB) ||
           (s == OP_SLT);
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin arbiter: scans last+1, last+2, ... mod NREQ.
// Ports: req, last, en in; one-hot grant (gated by en), idx out.
module rr_arbiter #(
  parameter  int NREQ = 2,
  localparam int IW   = (NREQ > 1) ? $clog2(NREQ) : 1
) (
  input  logic [NREQ-1:0] req,
  input  logic [IW-1:0]   last,
  input  logic            en,
  output logic [NREQ-1:0] grant,
  output logic [IW-1:0]   idx
);

  logic found;
  int   j;

  always_comb begin
    grant = '0;
    idx   = '0;
    found = 1'b0;
    j     = 0;
    for (int k = 1; k <= NREQ; k++) begin
      j = (int'(last) + k) % NREQ;
      if (!found && req[j]) begin
        found    = 1'b1;
        grant[j] = en;
        idx      = IW'(j);
      end
    end
  end

endmodule

// File: rtl/alu_share_ctrl.sv
// Round-robin front end sharing one combinational ALU among NREQ
// requesters. Ports: clk, reset (async, active-high); req,
// req_dataA/B, req_signal (packed per requester); ack (one-hot
// accept); rsp_valid/rsp_ready/rsp_data/rsp_err response;
// alu_dataA/B, alu_signal to the ALU, alu_dataOut back.
// Optional macro ALU_OP_CHECK_EN: reject illegal funct codes with
// rsp_err=1 and rsp_data=0, skipping the ALU; undefined, rsp_err=0.
module alu_share_ctrl
  import alu_pkg::*;
#(
  parameter int NREQ  = 2,
  parameter int WIDTH = WIDTH_DEF
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [NREQ-1:0]       req,
  input  logic [NREQ*WIDTH-1:0] req_dataA,
  input  logic [NREQ*WIDTH-1:0] req_dataB,
  input  logic [NREQ*6-1:0]     req_signal,
  output logic [NREQ-1:0]       ack,
  output logic [NREQ-1:0]       rsp_valid,
  input  logic [NREQ-1:0]       rsp_ready,
  output logic [WIDTH-1:0]      rsp_data,
  output logic                  rsp_err,
  output logic [WIDTH-1:0]      alu_dataA,
  output logic [WIDTH-1:0]      alu_dataB,
  output logic [5:0]            alu_signal,
  input  logic [WIDTH-1:0]      alu_dataOut
);

  localparam int IW = (NREQ > 1) ? $clog2(NREQ) : 1;

  logic [1:0]       state;
  logic [IW-1:0]    owner;
  logic [IW-1:0]    last;
  logic [IW-1:0]    gidx;
  logic [NREQ-1:0]  grant;
  logic             en;
  logic             op_ok;
  logic [WIDTH-1:0] sel_a;
  logic [WIDTH-1:0] sel_b;
  logic [5:0]       sel_sig;

  // Reset forces ack low even while req is held.
  assign en = (state == IDLE) && !reset;

  rr_arbiter #(.NREQ(NREQ)) u_arb (
    .req   (req),
    .last  (last),
    .en    (en),
    .grant (grant),
    .idx   (gidx)
  );

  assign ack     = grant;
  assign sel_a   = req_dataA[gidx*WIDTH +: WIDTH];
  assign sel_b   = req_dataB[gidx*WIDTH +: WIDTH];
  assign sel_sig = req_signal[gidx*6 +: 6];

`ifdef ALU_OP_CHECK_EN
  logic err_q;
  assign op_ok   = op_legal(sel_sig);
  assign rsp_err = err_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      err_q <= 1'b0;
    end else if (|grant) begin
      err_q <= !op_ok;
    end
  end
`else
  assign op_ok   = 1'b1;
  assign rsp_err = 1'b0;
`endif

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= IDLE;
      owner      <= '0;
      last       <= IW'(NREQ - 1);
      rsp_data   <= '0;
      alu_dataA  <= '0;
      alu_dataB  <= '0;
      alu_signal <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (|grant) begin
            owner <= gidx;
            last  <= gidx;
            if (op_ok) begin
              alu_dataA  <= sel_a;
              alu_dataB  <= sel_b;
              alu_signal <= sel_sig;
              state      <= EXEC;
            end else begin
              // Operands stay put so the ALU does not toggle.
              rsp_data <= '0;
              state    <= RESP;
            end
          end
        end
        EXEC: begin
          rsp_data <= alu_dataOut;
          state    <= RESP;
        end
        RESP: begin
          if (rsp_ready[owner]) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  always_comb begin
    rsp_valid = '0;
    if (state == RESP) rsp_valid[owner] = 1'b1;
  end

endmodule

// File: tb/tb_alu_share_ctrl.sv
// Bench for alu_share_ctrl: directed scenarios plus random traffic,
// scoreboarded against a transaction-level round-robin model.
module tb_alu_share_ctrl;
  import alu_pkg::*;

  localparam int NREQ = 3;
  localparam int W    = 32;
`ifdef ALU_OP_CHECK_EN
  localparam bit CHK = 1'b1;
`else
  localparam bit CHK = 1'b0;
`endif

  logic              clk = 1'b0;
  logic              reset;
  logic [NREQ-1:0]   req, ack, rsp_valid, rsp_ready;
  logic [NREQ*W-1:0] req_dataA, req_dataB;
  logic [NREQ*6-1:0] req_signal;
  logic [W-1:0]      rsp_data, alu_dataA, alu_dataB, alu_dataOut;
  logic              rsp_err;
  logic [5:0]        alu_signal;

  alu_share_ctrl #(.NREQ(NREQ), .WIDTH(W)) dut (
    .clk         (clk),
    .reset       (reset),
    .req         (req),
    .req_dataA   (req_dataA),
    .req_dataB   (req_dataB),
    .req_signal  (req_signal),
    .ack         (ack),
    .rsp_valid   (rsp_valid),
    .rsp_ready   (rsp_ready),
    .rsp_data    (rsp_data),
    .rsp_err     (rsp_err),
    .alu_dataA   (alu_dataA),
    .alu_dataB   (alu_dataB),
    .alu_signal  (alu_signal),
    .alu_dataOut (alu_dataOut)
  );

  function automatic logic [W-1:0] ref_alu(logic [5:0] s,
                                           logic [W-1:0] a,
                                           logic [W-1:0] b);
    case (s)
      6'd36:   return a & b;
      6'd37:   return a | b;
      6'd32:   return a + b;
      6'd34:   return a - b;
      6'd42:   return ($signed(a) < $signed(b)) ? 1 : 0;
      default: return a ^ b;
    endcase
  endfunction

  function automatic bit legal(logic [5:0] s);
    return s == 6'd36 || s == 6'd37 || s == 6'd32 ||
           s == 6'd34 || s == 6'd42;
  endfunction

  function automatic int next_grant(int lst, logic [NREQ-1:0] r);
    for (int k = 1; k <= NREQ; k++)
      if (r[(lst + k) % NREQ]) return (lst + k) % NREQ;
    return 0;
  endfunction

  assign alu_dataOut = ref_alu(alu_signal, alu_dataA, alu_dataB);

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int passes = 0;
  int total  = 0;

  task automatic chk(input bit ok, input string nm,
                     input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (ok) passes++;
    else $display("FAIL %s: got %0h want %0h (cycle %0d)",
                  nm, act, exp, cyc);
  endtask

  typedef struct {
    int         owner;
    logic [W-1:0] data;
    logic       err;
    int         lat;
  } exp_t;

  exp_t sb[$];
  int   ack_log[$];
  int   ack_cyc_log[$];

  bit         busy;
  int         free_cyc, rr_last, ack_cyc;
  logic [W-1:0] mdl_a, mdl_b;
  logic [5:0] mdl_s;

  // Monitor: predicts grants and responses at transaction level.
  always @(negedge clk) begin
    logic [NREQ-1:0] ev, ea;
    logic [W-1:0]    a, b;
    logic [5:0]      s;
    int              g;
    exp_t            e;
    if (reset) begin
      busy = 0; free_cyc = 0; rr_last = NREQ - 1;
      sb.delete();
      mdl_a = '0; mdl_b = '0; mdl_s = '0;
    end else begin
      ev = '0;
      if (busy && sb.size() > 0) begin
        e = sb[0];
        if (cyc - ack_cyc >= e.lat) ev[e.owner] = 1'b1;
      end
      if (ev != 0 || rsp_valid != 0)
        chk(rsp_valid === ev, "rsp_valid", 64'(rsp_valid), 64'(ev));
      if (ev != 0) begin
        chk(rsp_data === e.data, "rsp_data", 64'(rsp_data), 64'(e.data));
        chk(rsp_err === e.err, "rsp_err", 64'(rsp_err), 64'(e.err));
        chk(alu_dataA === mdl_a && alu_dataB === mdl_b,
            "alu_data", {alu_dataA, alu_dataB}, {mdl_a, mdl_b});
        chk(alu_signal === mdl_s, "alu_signal",
            64'(alu_signal), 64'(mdl_s));
        if (rsp_ready[e.owner]) begin
          void'(sb.pop_front());
          busy = 0;
          free_cyc = cyc + 1;
        end
      end
      ea = '0;
      g  = 0;
      if (!busy && cyc >= free_cyc && req != 0) begin
        g = next_grant(rr_last, req);
        ea[g] = 1'b1;
      end
      if (ea != 0 || ack != 0)
        chk(ack === ea, "ack", 64'(ack), 64'(ea));
      if (ea != 0) begin
        rr_last = g; busy = 1; ack_cyc = cyc;
        ack_log.push_back(g);
        ack_cyc_log.push_back(cyc);
        a = req_dataA[g*W +: W];
        b = req_dataB[g*W +: W];
        s = req_signal[g*6 +: 6];
        e.owner = g;
        if (legal(s) || !CHK) begin
          e.data = ref_alu(s, a, b); e.err = 0; e.lat = 2;
          mdl_a = a; mdl_b = b; mdl_s = s;
        end else begin
          e.data = '0; e.err = 1; e.lat = 1;
        end
        sb.push_back(e);
      end
    end
  end

  task automatic set_req(input int i, input logic [5:0] s,
                         input logic [W-1:0] a, input logic [W-1:0] b);
    req[i] = 1'b1;
    req_signal[i*6 +: 6] = s;
    req_dataA[i*W +: W] = a;
    req_dataB[i*W +: W] = b;
  endtask

  // Drops each requester in the cycle after its ack.
  task automatic serve(input logic [NREQ-1:0] m);
    logic [NREQ-1:0] pend, a;
    int n;
    pend = m; n = 0;
    while (pend != 0 && n < 60) begin
      @(negedge clk); #1;
      a = ack & pend;
      @(posedge clk); #1;
      req = req & ~a;
      pend = pend & ~a;
      n++;
    end
    chk(pend == 0, "ack_timeout", 64'(pend), 64'(0));
  endtask

  task automatic drain(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    @(posedge clk); #1 reset = 1'b1;
    @(posedge clk); #1 reset = 1'b0;
  endtask

  function automatic logic [5:0] pick_op();
    int r;
    r = $urandom % 8;
    case (r)
      0: return OP_AND;
      1: return OP_OR;
      2, 3: return OP_ADD;
      4: return OP_SUB;
      5, 6: return OP_SLT;
      default: return 6'($urandom % 64);
    endcase
  endfunction

  initial begin
    logic [NREQ-1:0] a;
    bit found;
    reset = 1'b0; req = '0; rsp_ready = '1;
    req_dataA = '0; req_dataB = '0; req_signal = '0;
    #1 reset = 1'b1;
    @(posedge clk); #1;
    chk(ack == 0 && rsp_valid == 0, "rst_hs",
        {ack, rsp_valid}, 64'(0));
    chk(rsp_data == 0 && rsp_err == 0, "rst_rsp",
        {rsp_err, rsp_data}, 64'(0));
    chk(alu_dataA == 0 && alu_dataB == 0 && alu_signal == 0,
        "rst_alu", {alu_dataA, alu_dataB}, 64'(0));
    @(posedge clk); #1 reset = 1'b0;

    // Single ADD from r0.
    set_req(0, OP_ADD, 5, 7);
    serve(3'b001);
    drain(4);

    // Simultaneous SUB/SLT right after reset: r0 first.
    do_reset();
    set_req(0, OP_SUB, 10, 3);
    set_req(1, OP_SLT, 3, 10);
    ack_log.delete();
    serve(3'b011);
    drain(4);
    chk(ack_log.size() == 2 && ack_log[0] == 0, "first_after_rst",
        64'(ack_log.size() > 0 ? ack_log[0] : -1), 64'(0));

    // Fairness with both held.
    ack_log.delete(); ack_cyc_log.delete();
    set_req(0, OP_ADD, 1, 2);
    set_req(1, OP_OR, 32'hf0, 32'h0f);
    for (int n = 0; n < 40 && ack_log.size() < 4; n++) begin
      @(negedge clk); #1;
    end
    @(posedge clk); #1 req = '0;
    chk(ack_log.size() >= 4, "fair_count",
        64'(ack_log.size()), 64'(4));
    if (ack_log.size() >= 4) begin
      for (int k = 0; k < 4; k++)
        chk(ack_log[k] == k % 2, "fair_order",
            64'(ack_log[k]), 64'(k % 2));
      for (int k = 1; k < 4; k++)
        chk(ack_cyc_log[k] - ack_cyc_log[k-1] == 3, "fair_period",
            64'(ack_cyc_log[k] - ack_cyc_log[k-1]), 64'(3));
    end
    drain(4);

    // Backpressure: r0 response held 5 cycles, r1 waiting.
    rsp_ready = '0;
    set_req(0, OP_SUB, 32'h10, 32'h20);
    serve(3'b001);
    set_req(1, OP_AND, 32'hff00, 32'h0ff0);
    found = 0;
    for (int n = 0; n < 10 && !found; n++) begin
      @(negedge clk); #1;
      found = rsp_valid[0];
    end
    chk(found, "bp_valid", 64'(rsp_valid), 64'(1));
    drain(5);
    rsp_ready = '1;
    serve(3'b010);
    drain(4);

    // Reset during EXEC, then r0 and r1 held.
    set_req(0, OP_ADD, 32'h1234, 32'h1111);
    found = 0;
    for (int n = 0; n < 10 && !found; n++) begin
      @(negedge clk); #1;
      found = ack[0];
    end
    chk(found, "pre_rst_ack", 64'(ack), 64'(1));
    @(posedge clk); #1;
    set_req(1, OP_OR, 3, 4);
    reset = 1'b1;
    #1;
    chk(ack == 0 && rsp_valid == 0, "mid_rst_hs",
        {ack, rsp_valid}, 64'(0));
    chk(rsp_data == 0 && rsp_err == 0, "mid_rst_rsp",
        {rsp_err, rsp_data}, 64'(0));
    chk(alu_dataA == 0 && alu_dataB == 0 && alu_signal == 0,
        "mid_rst_alu", {alu_dataA, alu_dataB}, 64'(0));
    @(posedge clk); #1 reset = 1'b0;
    ack_log.delete();
    serve(3'b011);
    drain(4);
    chk(ack_log.size() > 0 && ack_log[0] == 0, "post_rst_grant",
        64'(ack_log.size() > 0 ? ack_log[0] : -1), 64'(0));

    // Illegal funct code from r2.
    set_req(2, 6'd0, 9, 6);
    serve(3'b100);
    drain(4);

    // Random traffic.
    for (int n = 0; n < 800; n++) begin
      @(negedge clk); #1;
      a = ack;
      @(posedge clk); #1;
      for (int i = 0; i < NREQ; i++) begin
        if (a[i] || !req[i]) begin
          req[i] = 1'b0;
          if ($urandom % 3 == 0)
            set_req(i, pick_op(), $urandom, $urandom);
        end
      end
      rsp_ready = NREQ'($urandom) | NREQ'($urandom);
    end
    req = '0;
    rsp_ready = '1;
    drain(6);

    $display("%0d/%0d checks passed", passes, total);
    $finish;
  end

endmodule
